// File: rtl/seq_detect_pkg.sv
// Shared constants, types and helpers for the programmable serial pattern detector.
package seq_detect_pkg;

  localparam int SD_MAX_LEN = 8;
  localparam int SD_MASK_W  = 64;

  localparam logic [SD_MASK_W-1:0] SD_DEF_PATTERN = 64'b01_0111;
  localparam int                   SD_DEF_LEN     = 6;
  localparam bit                   SD_DEF_OVERLAP = 1'b1;

  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_ARMED   = 1'b1
  } fill_state_e;

  // Low-bit mask of length len, clamped to max_len; callers slice the low bits they need.
  function automatic logic [SD_MASK_W-1:0] len_mask(input int unsigned len,
                                                    input int unsigned max_len);
    logic [SD_MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SD_MASK_W; i++) begin
      if ((i < len) && (i < max_len)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the counter at one.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with overlap control and a saturating
// match counter. Define SEQ_DETECT_MASK_EN to add per-bit don't-care control (cfg_care).
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN     = SD_MAX_LEN,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SD_DEF_PATTERN),
  parameter int                 DEF_LEN     = SD_DEF_LEN,
  parameter bit                 DEF_OVERLAP = SD_DEF_OVERLAP
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [MAX_LEN-1:0] cfg_care,
`endif
  input  logic               din_valid,
  input  logic               din,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;
  fill_state_e        state_q, state_d;
  logic [MAX_LEN-1:0] care_v;

`ifdef SEQ_DETECT_MASK_EN
  logic [MAX_LEN-1:0] care_q, care_d;
  assign care_v = care_q;
`else
  assign care_v = '1;
`endif

  logic [LEN_W-1:0]     len_eff, len_eff_d;
  logic [SD_MASK_W-1:0] mask_full;
  logic [MAX_LEN-1:0]   mask;
  logic [MAX_LEN-1:0]   hist_nx;
  logic [LEN_W-1:0]     fill_nx;
  logic                 hit;

  assign len_eff   = (len_q > LEN_MAX) ? LEN_MAX : len_q;
  assign len_eff_d = (len_d > LEN_MAX) ? LEN_MAX : len_d;
  assign mask_full = len_mask(32'(len_q), MAX_LEN);
  assign mask      = mask_full[MAX_LEN-1:0] & care_v;
  assign hist_nx   = {hist_q[MAX_LEN-2:0], din};
  assign fill_nx   = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);

  // Compare against the post-shift history so the bit being accepted participates.
  assign hit = din_valid && !cfg_we && (len_eff != '0) && (fill_nx >= len_eff) &&
               (((hist_nx ^ pattern_q) & mask) == '0);

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = hit;
`ifdef SEQ_DETECT_MASK_EN
    care_d    = care_q;
`endif
    if (cfg_we) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
`ifdef SEQ_DETECT_MASK_EN
      care_d    = cfg_care;
`endif
    end else if (din_valid) begin
      hist_d = hist_nx;
      fill_d = (hit && !overlap_q) ? '0 : fill_nx;
    end
    state_d = ((len_eff_d != '0) && (fill_d >= len_eff_d)) ? ST_ARMED : ST_FILLING;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      state_q   <= ST_FILLING;
`ifdef SEQ_DETECT_MASK_EN
      care_q    <= '1;
`endif
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      state_q   <= state_d;
`ifdef SEQ_DETECT_MASK_EN
      care_q    <= care_d;
`endif
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (hit),
    .clr  (cnt_clr),
    .cnt  (match_cnt)
  );

  assign match = match_q;
  assign armed = (state_q == ST_ARMED);

endmodule
